// File: rtl/crtc_pkg.sv
// rtl/crtc_pkg.sv - shared constants, FSM states and mode record for the CRTC mode controller
package crtc_pkg;

  localparam logic [3:0] ADDR_HA       = 4'd0;
  localparam logic [3:0] ADDR_HFW      = 4'd1;
  localparam logic [3:0] ADDR_HSW      = 4'd2;
  localparam logic [3:0] ADDR_HBW      = 4'd3;
  localparam logic [3:0] ADDR_VA       = 4'd4;
  localparam logic [3:0] ADDR_VFW      = 4'd5;
  localparam logic [3:0] ADDR_VSW      = 4'd6;
  localparam logic [3:0] ADDR_VBW      = 4'd7;
  localparam logic [3:0] ADDR_PCLK_SEL = 4'd8;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_MODE = 2'd1;
  localparam logic [1:0] ERR_PLL  = 2'd2;

  localparam int unsigned MAX_TOTAL = 4095;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DRAIN,
    RESET,
    APPLY,
    LOCK_WAIT,
    RELEASE
  } state_e;

  typedef struct packed {
    logic [11:0] ha;
    logic [11:0] hfw;
    logic [11:0] hsw;
    logic [11:0] hbw;
    logic [11:0] va;
    logic [11:0] vfw;
    logic [11:0] vsw;
    logic [11:0] vbw;
    logic [2:0]  pclk_sel;
  } mode_t;

endpackage

// File: rtl/crtc_mode_ctrl_if.sv
// rtl/crtc_mode_ctrl_if.sv - CPU-side register/commit bus of the CRTC mode controller
interface crtc_mode_ctrl_if;
  logic        wr_i;
  logic [3:0]  addr_i;
  logic [11:0] data_i;
  logic [11:0] rdata_o;
  logic        commit_i;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  err_o;
  logic        err_valid_o;

  modport master (
    output wr_i, addr_i, data_i, commit_i,
    input  rdata_o, busy_o, done_o, err_o, err_valid_o
  );

  modport slave (
    input  wr_i, addr_i, data_i, commit_i,
    output rdata_o, busy_o, done_o, err_o, err_valid_o
  );
endinterface

// File: rtl/crtc_mode_regs.sv
// rtl/crtc_mode_regs.sv - shadow timing register file with write decode and readback mux
module crtc_mode_regs
  import crtc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic [3:0]  addr_i,
  input  logic [11:0] data_i,
  output logic [11:0] rdata_o,
  output mode_t       shadow_o
);

  mode_t shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_i) begin
      case (addr_i)
        ADDR_HA:       shadow_d.ha       = data_i;
        ADDR_HFW:      shadow_d.hfw      = data_i;
        ADDR_HSW:      shadow_d.hsw      = data_i;
        ADDR_HBW:      shadow_d.hbw      = data_i;
        ADDR_VA:       shadow_d.va       = data_i;
        ADDR_VFW:      shadow_d.vfw      = data_i;
        ADDR_VSW:      shadow_d.vsw      = data_i;
        ADDR_VBW:      shadow_d.vbw      = data_i;
        ADDR_PCLK_SEL: shadow_d.pclk_sel = data_i[2:0];
        default:       shadow_d          = shadow_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      ADDR_HA:       rdata_o = shadow_q.ha;
      ADDR_HFW:      rdata_o = shadow_q.hfw;
      ADDR_HSW:      rdata_o = shadow_q.hsw;
      ADDR_HBW:      rdata_o = shadow_q.hbw;
      ADDR_VA:       rdata_o = shadow_q.va;
      ADDR_VFW:      rdata_o = shadow_q.vfw;
      ADDR_VSW:      rdata_o = shadow_q.vsw;
      ADDR_VBW:      rdata_o = shadow_q.vbw;
      ADDR_PCLK_SEL: rdata_o = {9'd0, shadow_q.pclk_sel};
      default:       rdata_o = '0;
    endcase
  end

  assign shadow_o = shadow_q;

endmodule

// File: rtl/crtc_mode_ctrl.sv
// rtl/crtc_mode_ctrl.sv - CRTC mode-change sequencer: validate, blank, reset, apply, PLL relock, enable
module crtc_mode_ctrl
  import crtc_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 64,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 1048576
) (
  input  logic            clk_i,
  input  logic            rst_i,
  crtc_mode_ctrl_if.slave bus,
  output logic            enable_o,
  output logic            prst_o,
  output logic [11:0]     ha_o,
  output logic [11:0]     hfw_o,
  output logic [11:0]     hsw_o,
  output logic [11:0]     hbw_o,
  output logic [11:0]     va_o,
  output logic [11:0]     vfw_o,
  output logic [11:0]     vsw_o,
  output logic [11:0]     vbw_o,
  output logic [2:0]      pclk_sel_o,
  output logic            pll_reconf_o,
  input  logic            pll_locked_i
);

  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);
  localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
  localparam logic [23:0] TMO_LAST   = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] LOCK_GUARD = 24'd2;
  localparam logic [2:0]  LOCK_QUAL  = 3'd4;

  mode_t       shadow;
  mode_t       live_q;
  state_e      state_q;
  logic [15:0] cnt_q;
  logic [23:0] tmo_q;
  logic [2:0]  run_q;
  logic        busy_q, done_q, err_valid_q, enable_q, prst_q, pll_reconf_q;
  logic [1:0]  err_q;

  logic [13:0] h_total, v_total;
  logic        mode_ok, lock_hit;

  crtc_mode_regs u_regs (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_i     (bus.wr_i),
    .addr_i   (bus.addr_i),
    .data_i   (bus.data_i),
    .rdata_o  (bus.rdata_o),
    .shadow_o (shadow)
  );

  assign h_total = 14'(shadow.ha) + 14'(shadow.hfw) + 14'(shadow.hsw) + 14'(shadow.hbw);
  assign v_total = 14'(shadow.va) + 14'(shadow.vfw) + 14'(shadow.vsw) + 14'(shadow.vbw);
  assign mode_ok = (shadow.ha != '0) && (shadow.va != '0) && (shadow.hsw != '0) &&
                   (shadow.vsw != '0) && (h_total <= 14'(MAX_TOTAL)) && (v_total <= 14'(MAX_TOTAL));

  // The PLL may still report the old lock for a couple of cycles after a reconf request.
  assign lock_hit = (tmo_q >= LOCK_GUARD) && pll_locked_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      run_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= ERR_NONE;
      err_valid_q  <= 1'b0;
      enable_q     <= 1'b0;
      prst_q       <= 1'b1;
      pll_reconf_q <= 1'b0;
      live_q       <= '0;
    end else begin
      done_q       <= 1'b0;
      err_valid_q  <= 1'b0;
      err_q        <= ERR_NONE;
      pll_reconf_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.commit_i) begin
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (!mode_ok) begin
            err_q       <= ERR_MODE;
            err_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            enable_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            cnt_q   <= '0;
            prst_q  <= 1'b1;
            state_q <= RESET;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RESET: begin
          if (cnt_q == RST_LAST) begin
            cnt_q   <= '0;
            state_q <= APPLY;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        APPLY: begin
          live_q       <= shadow;
          pll_reconf_q <= 1'b1;
          tmo_q        <= '0;
          run_q        <= '0;
          state_q      <= LOCK_WAIT;
        end
        LOCK_WAIT: begin
          if (tmo_q != '1) tmo_q <= tmo_q + 24'd1;
          if (lock_hit) begin
            if (run_q != LOCK_QUAL) run_q <= run_q + 3'd1;
          end else begin
            run_q <= '0;
          end
          if (lock_hit && (run_q == LOCK_QUAL - 3'd1)) begin
            prst_q  <= 1'b0;
            state_q <= RELEASE;
          end else if (tmo_q == TMO_LAST) begin
            err_q       <= ERR_PLL;
            err_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        RELEASE: begin
          enable_q <= 1'b1;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.err_valid_o = err_valid_q;
  assign enable_o        = enable_q;
  assign prst_o          = prst_q;
  assign pll_reconf_o    = pll_reconf_q;
  assign ha_o            = live_q.ha;
  assign hfw_o           = live_q.hfw;
  assign hsw_o           = live_q.hsw;
  assign hbw_o           = live_q.hbw;
  assign va_o            = live_q.va;
  assign vfw_o           = live_q.vfw;
  assign vsw_o           = live_q.vsw;
  assign vbw_o           = live_q.vbw;
  assign pclk_sel_o      = live_q.pclk_sel;

endmodule

// File: tb/tb_crtc_mode_ctrl.sv
// tb/tb_crtc_mode_ctrl.sv - self-checking bench for crtc_mode_ctrl
module tb_crtc_mode_ctrl;
  import crtc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crtc_mode_ctrl_if bus();
  logic        enable, prst, pll_reconf, pll_locked;
  logic [11:0] ha, hfw, hsw, hbw, va, vfw, vsw, vbw;
  logic [2:0]  pclk_sel;

  crtc_mode_ctrl #(.DRAIN_CYCLES(64), .RST_CYCLES(16), .LOCK_TIMEOUT(100)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .enable_o(enable), .prst_o(prst),
    .ha_o(ha), .hfw_o(hfw), .hsw_o(hsw), .hbw_o(hbw), .va_o(va), .vfw_o(vfw), .vsw_o(vsw), .vbw_o(vbw),
    .pclk_sel_o(pclk_sel), .pll_reconf_o(pll_reconf), .pll_locked_i(pll_locked)
  );

  typedef struct { logic [3:0] addr; logic [11:0] wdata; logic [11:0] exp; bit do_wr; } reg_t;
  typedef struct { mode_t m; logic [1:0] err; int pll; int lat; } vec_t;
  typedef struct { logic [1:0] err; mode_t live; int lat; logic en; logic prst; } exp_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     pll_mode = 0;
  int     pll_k = -1;
  reg_t   rt[7];
  vec_t   tv[9];
  exp_t   sb[$];
  mode_t  exp_live;
  logic   exp_en, exp_prst;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  function automatic mode_t mk(int a, int b, int c, int d, int e, int f, int g, int h, int s);
    mode_t m;
    m.ha = 12'(a); m.hfw = 12'(b); m.hsw = 12'(c); m.hbw = 12'(d);
    m.va = 12'(e); m.vfw = 12'(f); m.vsw = 12'(g); m.vbw = 12'(h);
    m.pclk_sel = 3'(s);
    return m;
  endfunction

  task automatic wr(input logic [3:0] a, input logic [11:0] d);
    bus.wr_i = 1'b1; bus.addr_i = a; bus.data_i = d;
    tick();
    bus.wr_i = 1'b0;
  endtask

  task automatic load(input mode_t m);
    wr(ADDR_HA, m.ha);   wr(ADDR_HFW, m.hfw); wr(ADDR_HSW, m.hsw); wr(ADDR_HBW, m.hbw);
    wr(ADDR_VA, m.va);   wr(ADDR_VFW, m.vfw); wr(ADDR_VSW, m.vsw); wr(ADDR_VBW, m.vbw);
    wr(ADDR_PCLK_SEL, {9'd0, m.pclk_sel});
  endtask

  // PLL model: lock drops 2 cycles after the reconf pulse, then follows the selected profile.
  initial begin
    pll_locked = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (pll_reconf) pll_k = 0;
      else if (pll_k >= 0) pll_k++;
      if (pll_k >= 0) begin
        case (pll_mode)
          0:       pll_locked = !(pll_k >= 2 && pll_k < 10);
          1:       pll_locked = (pll_k < 2);
          default: pll_locked = (pll_k != 5);
        endcase
      end
    end
  end

  task automatic run_vec(input int i);
    exp_t  e;
    int    t0, en_fall, prst_rise, rc;
    bit    got, prev_en, prev_prst;
    string p;
    p = $sformatf("v%0d", i);
    load(tv[i].m);
    pll_mode  = tv[i].pll;
    prev_en   = exp_en;
    prev_prst = exp_prst;
    if (tv[i].err != ERR_MODE) exp_live = tv[i].m;
    if (tv[i].err == ERR_NONE) begin exp_en = 1'b1; exp_prst = 1'b0; end
    if (tv[i].err == ERR_PLL)  begin exp_en = 1'b0; exp_prst = 1'b1; end
    e.err = tv[i].err; e.live = exp_live; e.lat = tv[i].lat; e.en = exp_en; e.prst = exp_prst;
    sb.push_back(e);
    t0 = cyc;
    bus.commit_i = 1'b1;
    tick();
    bus.commit_i = 1'b0;
    check({p, "_busy_on"}, 32'(bus.busy_o), 1);
    en_fall = -1; prst_rise = -1; rc = 0; got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      if (bus.done_o || bus.err_valid_o) begin
        got = 1'b1;
      end else begin
        if (en_fall < 0 && !enable) en_fall = cyc - t0;
        if (prst_rise < 0 && prst) prst_rise = cyc - t0;
        if (pll_reconf) rc++;
        bus.commit_i = (tv[i].pll == 2) && ((cyc - t0) % 20 == 5);
        tick();
        bus.commit_i = 1'b0;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      check({p, "_result_timeout"}, 0, 1);
    end else begin
      check({p, "_done"},    32'(bus.done_o), 32'(e.err == ERR_NONE));
      check({p, "_errv"},    32'(bus.err_valid_o), 32'(e.err != ERR_NONE));
      check({p, "_err"},     32'(bus.err_o), 32'(e.err));
      check({p, "_latency"}, cyc - t0, e.lat);
      check({p, "_busy_off"}, 32'(bus.busy_o), 0);
      check({p, "_enable"},  32'(enable), 32'(e.en));
      check({p, "_prst"},    32'(prst), 32'(e.prst));
      check({p, "_reconf_pulses"}, rc, (e.err == ERR_MODE) ? 0 : 1);
      if (prev_en)    check({p, "_en_fall"}, en_fall, (e.err == ERR_MODE) ? -1 : 2);
      if (!prev_prst) check({p, "_prst_rise"}, prst_rise, (e.err == ERR_MODE) ? -1 : 66);
      check({p, "_ha"},  32'(ha),  32'(e.live.ha));
      check({p, "_hfw"}, 32'(hfw), 32'(e.live.hfw));
      check({p, "_hsw"}, 32'(hsw), 32'(e.live.hsw));
      check({p, "_hbw"}, 32'(hbw), 32'(e.live.hbw));
      check({p, "_va"},  32'(va),  32'(e.live.va));
      check({p, "_vfw"}, 32'(vfw), 32'(e.live.vfw));
      check({p, "_vsw"}, 32'(vsw), 32'(e.live.vsw));
      check({p, "_vbw"}, 32'(vbw), 32'(e.live.vbw));
      check({p, "_pclk"}, 32'(pclk_sel), 32'(e.live.pclk_sel));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rt[0] = '{4'd0,  12'hABC, 12'hABC, 1'b1};
    rt[1] = '{4'd8,  12'hFFF, 12'h007, 1'b1};
    rt[2] = '{4'd9,  12'h123, 12'h000, 1'b1};
    rt[3] = '{4'd15, 12'hFFF, 12'h000, 1'b1};
    rt[4] = '{4'd0,  12'h000, 12'hABC, 1'b0};
    rt[5] = '{4'd7,  12'h800, 12'h800, 1'b1};
    rt[6] = '{4'd4,  12'h001, 12'h001, 1'b1};

    tv[0] = '{mk(640, 16, 96, 48, 480, 10, 2, 33, 1),     ERR_NONE, 0, 98};
    tv[1] = '{mk(3000, 1000, 96, 0, 480, 10, 2, 33, 1),   ERR_MODE, 0, 2};
    tv[2] = '{mk(640, 16, 0, 48, 480, 10, 2, 33, 1),      ERR_MODE, 0, 2};
    tv[3] = '{mk(640, 16, 44, 48, 480, 10, 2, 33, 1),     ERR_NONE, 0, 98};
    tv[4] = '{mk(640, 16, 96, 48, 0, 10, 2, 33, 2),       ERR_MODE, 0, 2};
    tv[5] = '{mk(4000, 50, 40, 5, 4000, 90, 4, 1, 7),     ERR_NONE, 0, 98};
    tv[6] = '{mk(800, 40, 128, 88, 600, 1, 0, 23, 3),     ERR_MODE, 0, 2};
    tv[7] = '{mk(1024, 24, 136, 160, 768, 3, 6, 29, 4),   ERR_PLL,  1, 183};
    tv[8] = '{mk(800, 40, 128, 88, 600, 1, 4, 23, 3),     ERR_NONE, 2, 94};

    rst = 1'b1;
    bus.wr_i = 1'b0; bus.addr_i = '0; bus.data_i = '0; bus.commit_i = 1'b0;
    exp_live = '0; exp_en = 1'b0; exp_prst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy",   32'(bus.busy_o), 0);
    check("rst_done",   32'(bus.done_o), 0);
    check("rst_errv",   32'(bus.err_valid_o), 0);
    check("rst_err",    32'(bus.err_o), 0);
    check("rst_enable", 32'(enable), 0);
    check("rst_prst",   32'(prst), 1);
    check("rst_reconf", 32'(pll_reconf), 0);
    check("rst_ha",     32'(ha), 0);
    check("rst_pclk",   32'(pclk_sel), 0);
    check("rst_rdata",  32'(bus.rdata_o), 0);

    for (int i = 0; i < 7; i++) begin
      if (rt[i].do_wr) wr(rt[i].addr, rt[i].wdata);
      bus.addr_i = rt[i].addr;
      #1;
      check($sformatf("reg%0d_rdata", i), 32'(bus.rdata_o), 32'(rt[i].exp));
    end
    check("live_untouched_by_wr", 32'(ha), 0);

    for (int i = 0; i < 9; i++) run_vec(i);

    repeat (5) tick();
    check("ignored_commit_busy", 32'(bus.busy_o), 0);
    check("ignored_commit_done", 32'(bus.done_o), 0);

    load(tv[0].m);
    pll_mode = 0;
    bus.commit_i = 1'b1;
    tick();
    bus.commit_i = 1'b0;
    repeat (10) tick();
    check("drain_enable", 32'(enable), 0);
    check("drain_busy",   32'(bus.busy_o), 1);
    bus.addr_i = ADDR_HA;
    rst = 1'b1;
    tick();
    check("midrst_busy",   32'(bus.busy_o), 0);
    check("midrst_enable", 32'(enable), 0);
    check("midrst_prst",   32'(prst), 1);
    check("midrst_ha",     32'(ha), 0);
    check("midrst_vbw",    32'(vbw), 0);
    check("midrst_rdata",  32'(bus.rdata_o), 0);
    rst = 1'b0;
    exp_live = '0; exp_en = 1'b0; exp_prst = 1'b1;
    repeat (3) tick();
    check("midrst_idle", 32'(bus.busy_o), 0);
    run_vec(0);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
